// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default configuration constants.
package uart_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t SEND = 2'd1;
   localparam state_t WAIT = 2'd2;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans requesters starting one past
// last_grant, wrapping around, and reports the first one with a request.
module rr_picker
   import uart_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last_grant,
   output logic               any,
   output logic [IDW-1:0]     winner
);

   localparam int SW = IDW + 1;

   logic [SW-1:0] pos;

   // Walk the offsets from farthest to nearest so the nearest hit is kept.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      pos    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         pos = {1'b0, last_grant} + SW'(k);
         if (pos >= SW'(NUM_REQ)) begin
            pos = pos - SW'(NUM_REQ);
         end
         if (req[pos[IDW-1:0]]) begin
            any    = 1'b1;
            winner = pos[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one UART
// transmitter. One frame at a time: IDLE picks a winner, SEND issues the
// start/ready pulses, WAIT holds the byte until the transmitter reports done.
// Optional watchdog on WAIT is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*8-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       active,
   output logic                       timeout_err
);

   localparam int IDW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   state_t             state_q, state_d;
   logic [IDW-1:0]     last_grant_q, last_grant_d;
   logic [IDW-1:0]     grant_id_q, grant_id_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic               active_q, active_d;
   logic               timeout_err_q, timeout_err_d;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WDW-1:0]     wd_q, wd_d;
`endif

   logic               pick_any;
   logic [IDW-1:0]     pick_id;
   logic [7:0]         pick_data;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_picker (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .any        (pick_any),
      .winner     (pick_id)
   );

   // Select the winning requester's byte.
   always_comb begin
      pick_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_id == IDW'(i)) begin
            pick_data = req_data[i*8 +: 8];
         end
      end
   end

   // Next-state and registered-output logic for the IDLE/SEND/WAIT FSM.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_id_d    = grant_id_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      req_ready_d   = '0;
      active_d      = active_q;
      timeout_err_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_d          = wd_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d     = SEND;
               grant_id_d  = pick_id;
               tx_data_d   = pick_data;
               tx_start_d  = 1'b1;
               req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
               active_d    = 1'b1;
            end
         end
         SEND: begin
            state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         WAIT: begin
            if (tx_done) begin
               state_d      = IDLE;
               active_d     = 1'b0;
               last_grant_d = grant_id_q;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
               state_d       = IDLE;
               active_d      = 1'b0;
               last_grant_d  = grant_id_q;
               timeout_err_d = 1'b1;
               wd_d          = '0;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
`endif
         end
         default: begin
            state_d  = IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any frame without emitting pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= IDW'(NUM_REQ - 1);
         grant_id_q    <= '0;
         tx_data_q     <= 8'h00;
         tx_start_q    <= 1'b0;
         req_ready_q   <= '0;
         active_q      <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         wd_q          <= '0;
`endif
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_id_q    <= grant_id_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         req_ready_q   <= req_ready_d;
         active_q      <= active_d;
         timeout_err_q <= timeout_err_d;
`ifdef UART_ARB_TIMEOUT_EN
         wd_q          <= wd_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign grant_id  = grant_id_q;
   assign active    = active_q;
`ifdef UART_ARB_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in clk cycles, used only under REQ-026.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 req_valid  input  NUM_REQ  bit i: requester i holds a byte to send.
REQ-006 req_data  input  NUM_REQ*8  byte of requester i at bits [8i+7:8i], LSB-first on the line.
REQ-007 req_ready  output  NUM_REQ  one-cycle pulse on bit i: byte of requester i accepted.
REQ-008 tx_start  output  1  one-cycle pulse to the transmitter: begin frame with tx_data.
REQ-009 tx_data  output  8  byte driven to the transmitter, stable from tx_start until frame end.
REQ-010 tx_done  input  1  one-cycle pulse from the transmitter: stop bit finished.
REQ-011 grant_id  output  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
REQ-012 active  output  1  high while a frame is owned (state SEND or WAIT).
REQ-013 timeout_err  output  1  one-cycle pulse: frame abandoned by watchdog.

Function
REQ-014 FSM states SHALL be IDLE, SEND, WAIT; all outputs registered.
REQ-015 IDLE with any req_valid set: pick winner by round-robin, latch req_data slice into tx_data, load grant_id, go SEND.
REQ-016 Round-robin: search starts at (last_grant+1) mod NUM_REQ, wraps, first set bit wins; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-017 SEND lasts exactly one cycle: tx_start=1 and req_ready[grant_id]=1 in that cycle, then go WAIT.
REQ-018 Latency: req_valid sampled high in IDLE at edge N gives tx_start/req_ready high during cycle N..N+1; requester holds valid and data until it sees req_ready.
REQ-019 WAIT: hold tx_data, grant_id, active=1; on tx_done=1 update last_grant=grant_id, go IDLE.
REQ-020 Minimum one IDLE cycle between frames; back-to-back requests give tx_start spacing of frame length + 2 cycles.
REQ-021 tx_done in IDLE or SEND SHALL be ignored; req_valid changes during SEND/WAIT SHALL not alter grant_id or tx_data.
REQ-022 req_valid deasserted before grant: no grant, no pulse; requester with valid low is skipped without pointer change.
REQ-023 At most one req_ready bit high in any cycle; tx_start and req_ready always coincide.

Reset
REQ-024 On reset: state IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, active=0, timeout_err=0, last_grant=NUM_REQ-1, watchdog=0.
REQ-025 Reset mid-frame (SEND/WAIT) SHALL abort ownership with no req_ready or timeout pulse; reset wins over a simultaneous tx_done.

Configuration
REQ-026 Macro UART_ARB_TIMEOUT_EN defined: watchdog counts cycles in WAIT; on reaching TIMEOUT_CYCLES without tx_done, pulse timeout_err, set last_grant=grant_id, go IDLE; tx_done on the same cycle wins (no error).
REQ-027 Macro undefined: no watchdog logic, WAIT waits indefinitely, timeout_err tied 0; port list unchanged.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state typedef (IDLE/SEND/WAIT), default NUM_REQ and TIMEOUT_CYCLES constants.
REQ-029 Round-robin search SHALL live in sub-module rr_picker (inputs: request vector, last_grant; outputs: any, winner index), purely combinational.

Verification
REQ-030 Single requester: reset, req_valid=4'b0100, req_data[23:16]=8'hA5 -> next cycle tx_start=1, req_ready=4'b0100, tx_data=8'hA5, grant_id=2; tx_done 100 cycles later -> active=0.
REQ-031 Fairness: all four valid continuously, bytes 8'h10/11/12/13 -> grant order 0,1,2,3,0; each tx_start carries its requester's byte.
REQ-032 Wrap: after grant to 3, req_valid=4'b1001 -> next grant is 0, then 3.
REQ-033 Spurious: tx_done pulsed in IDLE, req_valid=0 -> no output change; reset asserted in WAIT with tx_done same cycle -> all outputs at reset values, no req_ready.
REQ-034 Watchdog (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): grant requester 1, never pulse tx_done -> timeout_err=1 for one cycle 16 cycles into WAIT, then IDLE, next grant starts search at 2.
REQ-035 Without macro, same stimulus -> active stays 1 for 2000 cycles, timeout_err never asserted.
